// File: rtl/warp_scoreboard.sv
// Register reservation scoreboard and in-order dual-dispatch gate for warp issue.
// Tracks in-flight writes to the 32 integer registers; x0 is never reserved.

module warp_sb_slot (
    input  logic [31:0] r,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        wr_en,
    output logic        hazard
);
    // r[0] is held at zero, so x0 operands never raise a hazard.
    assign hazard = r[rs1] | r[rs2] | (wr_en & r[rd]);
endmodule

module warp_scoreboard (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inst0_valid,
    input  logic [4:0]  i_inst0_rs1,
    input  logic [4:0]  i_inst0_rs2,
    input  logic [4:0]  i_inst0_rd,
    input  logic        i_inst0_wr_en,
    input  logic        i_inst0_fu_ready,
    input  logic        i_inst1_valid,
    input  logic [4:0]  i_inst1_rs1,
    input  logic [4:0]  i_inst1_rs2,
    input  logic [4:0]  i_inst1_rd,
    input  logic        i_inst1_wr_en,
    input  logic        i_inst1_fu_ready,
    output logic        o_inst0_dispatch,
    output logic        o_inst1_dispatch,
    input  logic        i_wb0_valid,
    input  logic [4:0]  i_wb0_rd,
    input  logic        i_wb1_valid,
    input  logic [4:0]  i_wb1_rd,
    output logic [31:0] o_reserved,
    output logic [5:0]  o_inflight,
    output logic        o_idle,
    output logic        o_wb_err
);
    localparam int NUM_SLOTS = 2;

    logic [31:0] r_q, r_d, set_mask, clr_mask;
    logic [5:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [NUM_SLOTS-1:0][4:0] slot_rs1, slot_rs2, slot_rd;
    logic [NUM_SLOTS-1:0]      slot_wr, slot_haz;

    assign slot_rs1 = {i_inst1_rs1, i_inst0_rs1};
    assign slot_rs2 = {i_inst1_rs2, i_inst0_rs2};
    assign slot_rd  = {i_inst1_rd,  i_inst0_rd};
    assign slot_wr  = {i_inst1_wr_en, i_inst0_wr_en};

    genvar s;
    generate
        for (s = 0; s < NUM_SLOTS; s++) begin : g_slot
            warp_sb_slot u_slot (
                .r      (r_q),
                .rs1    (slot_rs1[s]),
                .rs2    (slot_rs2[s]),
                .rd     (slot_rd[s]),
                .wr_en  (slot_wr[s]),
                .hazard (slot_haz[s])
            );
        end
    endgenerate

    // Slot 1 must also see slot 0's destination, which is not yet in r_q.
    logic intra_haz;
    assign intra_haz = i_inst0_wr_en && (i_inst0_rd != 5'd0) &&
                       ((i_inst1_rs1 == i_inst0_rd) || (i_inst1_rs2 == i_inst0_rd) ||
                        (i_inst1_wr_en && (i_inst1_rd == i_inst0_rd)));

    assign o_inst0_dispatch = i_rst_n & i_inst0_valid & i_inst0_fu_ready & ~slot_haz[0];
    assign o_inst1_dispatch = i_rst_n & i_inst1_valid & i_inst1_fu_ready & ~slot_haz[1] &
                              ~intra_haz & o_inst0_dispatch;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (o_inst0_dispatch && i_inst0_wr_en && i_inst0_rd != 5'd0)
            set_mask = set_mask | (32'd1 << i_inst0_rd);
        if (o_inst1_dispatch && i_inst1_wr_en && i_inst1_rd != 5'd0)
            set_mask = set_mask | (32'd1 << i_inst1_rd);
        if (i_wb0_valid && i_wb0_rd != 5'd0)
            clr_mask = clr_mask | (32'd1 << i_wb0_rd);
        if (i_wb1_valid && i_wb1_rd != 5'd0)
            clr_mask = clr_mask | (32'd1 << i_wb1_rd);
        // Set after clear: a fresh reservation belongs to the younger instruction.
        r_d = (r_q & ~clr_mask) | set_mask;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 1; i < 32; i++)
            cnt_d = cnt_d + {5'd0, r_d[i]};
    end

    always_comb begin
        err_d = err_q;
        if (i_wb0_valid && i_wb0_rd != 5'd0 && !r_q[i_wb0_rd])
            err_d = 1'b1;
        if (i_wb1_valid && i_wb1_rd != 5'd0 && !r_q[i_wb1_rd])
            err_d = 1'b1;
        if (i_wb0_valid && i_wb1_valid && i_wb0_rd != 5'd0 && i_wb0_rd == i_wb1_rd)
            err_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q   <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_reserved = r_q;
    assign o_inflight = cnt_q;
    assign o_idle     = (r_q == 32'd0);
    assign o_wb_err   = err_q;
endmodule

// File: tb/tb_warp_scoreboard.sv
// Bench for warp_scoreboard: directed vector table, reset/error sequences,
// then randomized traffic against a register-array reference model.

module tb_warp_scoreboard;
    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       wr, fu;
    } inst_t;

    typedef struct {
        inst_t     i0, i1;
        bit        w0v;
        bit [4:0]  w0rd;
        bit        w1v;
        bit [4:0]  w1rd;
        bit        e0, e1;
        bit [31:0] eres;
        bit        eerr;
    } vec_t;

    logic        clk = 0, rst_n = 0;
    inst_t       c0, c1;
    logic        w0v, w1v;
    logic [4:0]  w0rd, w1rd;
    logic        d0, d1, idle, wb_err;
    logic [31:0] reserved;
    logic [5:0]  inflight;

    int n_cmp = 0, n_bad = 0;
    bit res_m[32];
    bit err_m;

    always #5 clk = ~clk;

    warp_scoreboard dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_inst0_valid(c0.v), .i_inst0_rs1(c0.rs1), .i_inst0_rs2(c0.rs2),
        .i_inst0_rd(c0.rd), .i_inst0_wr_en(c0.wr), .i_inst0_fu_ready(c0.fu),
        .i_inst1_valid(c1.v), .i_inst1_rs1(c1.rs1), .i_inst1_rs2(c1.rs2),
        .i_inst1_rd(c1.rd), .i_inst1_wr_en(c1.wr), .i_inst1_fu_ready(c1.fu),
        .o_inst0_dispatch(d0), .o_inst1_dispatch(d1),
        .i_wb0_valid(w0v), .i_wb0_rd(w0rd), .i_wb1_valid(w1v), .i_wb1_rd(w1rd),
        .o_reserved(reserved), .o_inflight(inflight), .o_idle(idle), .o_wb_err(wb_err)
    );

    function automatic inst_t mk(bit v, bit [4:0] a, bit [4:0] b, bit [4:0] d, bit w, bit f);
        inst_t x;
        x.v = v; x.rs1 = a; x.rs2 = b; x.rd = d; x.wr = w; x.fu = f;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(inst_t a, inst_t b, bit v0, bit [4:0] r0, bit v1, bit [4:0] r1);
        c0 = a; c1 = b; w0v = v0; w0rd = r0; w1v = v1; w1rd = r1;
    endtask

    // Reference model: a per-register busy flag list, applied with the scoreboard rules.
    function automatic bit m_busy(bit [4:0] r);
        return (r != 0) && res_m[r];
    endfunction

    function automatic bit m_haz(inst_t x);
        return m_busy(x.rs1) || m_busy(x.rs2) || (x.wr && m_busy(x.rd));
    endfunction

    function automatic bit [31:0] m_vec();
        bit [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = res_m[i];
        return v;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(res_m[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) res_m[i] = 0;
        err_m = 0;
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic mstep();
        bit e0, e1, blocked1;
        blocked1 = c0.wr && c0.rd != 0 &&
                   (c1.rs1 == c0.rd || c1.rs2 == c0.rd || (c1.wr && c1.rd == c0.rd));
        e0 = c0.v && c0.fu && !m_haz(c0);
        e1 = c1.v && c1.fu && !m_haz(c1) && !blocked1 && e0;
        #2;
        chk("m_dispatch0", d0, e0);
        chk("m_dispatch1", d1, e1);
        @(posedge clk); #1;
        if (w0v && w0rd != 0 && !res_m[w0rd]) err_m = 1;
        if (w1v && w1rd != 0 && !res_m[w1rd]) err_m = 1;
        if (w0v && w1v && w0rd != 0 && w0rd == w1rd) err_m = 1;
        if (w0v) res_m[w0rd] = 0;
        if (w1v) res_m[w1rd] = 0;
        if (e0 && c0.wr) res_m[c0.rd] = 1;
        if (e1 && c1.wr) res_m[c1.rd] = 1;
        res_m[0] = 0;
        chk("m_reserved", reserved, m_vec());
        chk("m_inflight", inflight, m_count());
        chk("m_idle", idle, m_count() == 0);
        chk("m_wb_err", wb_err, err_m);
    endtask

    function automatic bit [4:0] pick_reserved();
        bit [4:0] q[$];
        for (int i = 1; i < 32; i++) if (res_m[i]) q.push_back(5'(i));
        if (q.size() == 0) return 5'($urandom_range(0, 7));
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    vec_t tbl[$];

    initial begin
        inst_t nn;
        vec_t  v;
        nn = mk(0, 0, 0, 0, 0, 0);
        drive(nn, nn, 0, 0, 0, 0);

        // {i0, i1, wb0 v/rd, wb1 v/rd, exp d0, d1, reserved after edge, err after edge}
        tbl.push_back('{mk(1,1,2,3,1,1), nn,              0,0, 0,0, 1,0, 32'h008, 0});
        tbl.push_back('{mk(1,3,0,0,0,1), mk(1,0,0,0,0,1), 1,3, 0,0, 0,0, 32'h000, 0});
        tbl.push_back('{mk(1,3,0,0,0,1), mk(1,0,0,0,0,1), 0,0, 0,0, 1,1, 32'h000, 0});
        tbl.push_back('{mk(1,0,0,5,1,1), mk(1,0,5,0,0,1), 0,0, 0,0, 1,0, 32'h020, 0});
        tbl.push_back('{nn,              nn,              1,5, 0,0, 0,0, 32'h000, 0});
        tbl.push_back('{mk(1,0,0,5,1,1), mk(1,6,0,7,1,1), 0,0, 0,0, 1,1, 32'h0A0, 0});
        tbl.push_back('{mk(1,1,0,0,0,0), mk(1,2,0,0,0,1), 0,0, 0,0, 0,0, 32'h0A0, 0});
        tbl.push_back('{mk(1,0,0,0,1,1), nn,              0,0, 0,0, 1,0, 32'h0A0, 0});
        tbl.push_back('{mk(1,5,0,0,0,1), mk(1,1,0,0,0,1), 1,7, 0,0, 0,0, 32'h020, 0});
        tbl.push_back('{mk(1,0,0,9,1,1), nn,              0,0, 0,0, 1,0, 32'h220, 0});
        tbl.push_back('{mk(1,0,0,9,1,1), nn,              1,9, 0,0, 0,0, 32'h020, 0});
        tbl.push_back('{mk(1,0,0,9,1,1), nn,              0,0, 1,9, 1,0, 32'h220, 1});
        tbl.push_back('{mk(1,0,0,4,1,1), nn,              1,5, 0,0, 1,0, 32'h210, 1});
        tbl.push_back('{nn,              mk(1,0,0,0,0,1), 0,0, 0,0, 0,0, 32'h210, 1});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_reserved", reserved, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_idle", idle, 1);
        chk("rst_wb_err", wb_err, 0);
        c0 = mk(1, 0, 0, 0, 0, 1);
        #1;
        chk("rst_dispatch0_forced", d0, 0);
        c0 = nn;
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.i0, v.i1, v.w0v, v.w0rd, v.w1v, v.w1rd);
            #2;
            chk($sformatf("vec%0d_dispatch0", i), d0, v.e0);
            chk($sformatf("vec%0d_dispatch1", i), d1, v.e1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_reserved", i), reserved, v.eres);
            chk($sformatf("vec%0d_inflight", i), inflight, $countones(v.eres));
            chk($sformatf("vec%0d_idle", i), idle, v.eres == 0);
            chk($sformatf("vec%0d_wb_err", i), wb_err, v.eerr);
        end

        // Asynchronous reset in the middle of a cycle clears state at once.
        drive(mk(1, 0, 0, 0, 0, 1), nn, 0, 0, 0, 0);
        #1 rst_n = 0;
        #1;
        chk("async_reserved", reserved, 0);
        chk("async_inflight", inflight, 0);
        chk("async_idle", idle, 1);
        chk("async_wb_err", wb_err, 0);
        chk("async_dispatch0", d0, 0);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Duplicate writeback of the same register.
        drive(mk(1, 0, 0, 4, 1, 1), nn, 0, 0, 0, 0);
        #2 chk("dup_dispatch0", d0, 1);
        @(posedge clk); #1;
        chk("dup_reserved_set", reserved, 32'h10);
        drive(nn, nn, 1, 4, 1, 4);
        @(posedge clk); #1;
        chk("dup_reserved_clr", reserved, 0);
        chk("dup_wb_err", wb_err, 1);
        drive(nn, nn, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("dup_err_sticky", wb_err, 1);

        rst_n = 0;
        #1 rst_n = 1;
        m_clear();
        @(posedge clk); #1;

        // Fill all 31 registers, then probe the full scoreboard.
        for (int k = 1; k <= 31; k += 2) begin
            c0 = mk(1, 0, 0, 5'(k), 1, 1);
            c1 = (k + 1 <= 31) ? mk(1, 0, 0, 5'(k + 1), 1, 1) : nn;
            w0v = 0; w1v = 0;
            mstep();
        end
        chk("full_inflight", inflight, 31);
        drive(mk(1, 7, 0, 0, 0, 1), mk(1, 0, 0, 0, 0, 1), 0, 0, 0, 0);
        mstep();
        drive(mk(1, 0, 0, 0, 0, 1), mk(1, 0, 0, 0, 1, 1), 0, 0, 0, 0);
        #2 chk("full_x0_dispatch0", d0, 1);
        #0 chk("full_x0_dispatch1", d1, 1);
        #0 chk("full_waw_probe_pre", inflight, 31);
        c0 = mk(1, 0, 0, 0, 0, 1);
        #0;
        // Realign to post-edge before model steps.
        @(posedge clk); #1;
        drive(mk(1, 0, 0, 12, 1, 1), nn, 0, 0, 0, 0);
        mstep();

        // Randomized traffic; writebacks mostly target live reservations.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                drive(nn, nn, 0, 0, 0, 0);
                rst_n = 0;
                #1 rst_n = 1;
                m_clear();
                @(posedge clk); #1;
            end
            c0 = mk($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            c1 = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            w0v = $urandom_range(0, 2) == 0;
            w0rd = ($urandom_range(0, 9) != 0) ? pick_reserved() : 5'($urandom_range(0, 15));
            w1v = $urandom_range(0, 3) == 0;
            w1rd = ($urandom_range(0, 9) != 0) ? pick_reserved() : 5'($urandom_range(0, 15));
            mstep();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/warp_scoreboard.md
# warp_scoreboard

Register reservation scoreboard and dual-dispatch gate for the warp issue stage. It tracks which of the 32 integer registers have an in-flight write. It decides, combinationally and in program order, whether the two bundle instructions presented by issue may leave this cycle. It sets reservations on dispatch and releases them on the two writeback ports, which removes RAW/WAW tracking from the issue datapath.

## Interface
- No parameters (32 registers, 2 dispatch slots, 2 writeback ports fixed).
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_inst0_valid  in  1  slot 0 (older) instruction present
- i_inst0_rs1, i_inst0_rs2, i_inst0_rd  in  5 each  slot 0 register addresses; unused sources encoded as 0
- i_inst0_wr_en  in  1  slot 0 writes rd
- i_inst0_fu_ready  in  1  target functional unit for slot 0 accepts this cycle
- i_inst1_valid, i_inst1_rs1, i_inst1_rs2, i_inst1_rd, i_inst1_wr_en, i_inst1_fu_ready  in  1/5/5/5/1/1  same fields for slot 1 (younger)
- o_inst0_dispatch  out  1  slot 0 leaves issue this cycle
- o_inst1_dispatch  out  1  slot 1 leaves issue this cycle
- i_wb0_valid, i_wb1_valid  in  1  writeback port retires a write
- i_wb0_rd, i_wb1_rd  in  5  register written back
- o_reserved  out  32  current reservation vector (bit 0 always 0)
- o_inflight  out  6  number of set reservation bits
- o_idle  out  1  no reservations outstanding
- o_wb_err  out  1  sticky protocol error

## Operation
- State: 32-bit reservation vector R, 6-bit count C, sticky err flag. Register 0 is never reserved; x0 reads and writes are never hazards.
- Slot 0 hazard h0 = R[rs1] | R[rs2] | (wr_en & R[rd]), using registered R only.
- o_inst0_dispatch = inst0_valid & fu_ready0 & !h0.
- Slot 1 hazard h1 = the same check against R, plus an intra-bundle check: if inst0_wr_en and inst0_rd != 0, slot 1 is blocked when rs1, rs2, or (wr_en & rd) equals inst0_rd.
- o_inst1_dispatch = inst1_valid & fu_ready1 & !h1 & o_inst0_dispatch. Slot 1 never dispatches unless slot 0 dispatches the same cycle, which keeps dispatch in order. inst1_valid without inst0_valid never dispatches.
- Set mask S: bit rd for each dispatching slot with wr_en and rd != 0.
- Clear mask K: bit rd for each valid writeback with rd != 0.
- Next state: R' = (R & ~K) | S. Set wins over clear on the same bit, because the new reservation belongs to the younger instruction.
- Writebacks do not release a register for dispatch in the same cycle. There is no bypass; release takes effect next cycle.
- C' = popcount(R'); o_inflight = C. o_idle = (R == 0).
- o_wb_err is set, and held until reset, when either of these occurs:
  - a valid writeback with rd != 0 finds R[rd] == 0;
  - both writebacks are valid with the same nonzero rd.
- On an error, the clear is still applied.

## Timing
- Dispatch outputs are combinational from the inputs and registered R, with zero-cycle latency. Issue treats dispatch as the valid&ready handshake with the FU.
- Reservation set or clear is visible on o_reserved, o_inflight and o_idle one cycle after the triggering edge.
- Reset asserted, asynchronous:
  - R = 0, C = 0, o_idle = 1, o_wb_err = 0;
  - o_inst0_dispatch and o_inst1_dispatch are forced 0 while i_rst_n is low.
- Reset mid-operation drops all reservations. Any later writebacks of pre-reset instructions flag o_wb_err; this is expected, since the pipeline is reset together.
- Boundary, all 31 reserved: C = 31; every instruction touching a reserved register stalls; an x0-only instruction with wr_en = 0 still dispatches.

## Test plan
- Reset, then inst0 {rs1=1, rs2=2, rd=3, wr_en} valid with fu_ready -> o_inst0_dispatch = 1; next cycle o_reserved = 0x8, o_inflight = 1, o_idle = 0.
- With R[3] set, inst0 rs1=3 -> no dispatch of either slot. Same cycle wb0 rd=3 -> no dispatch that cycle; next cycle dispatch = 1.
- Bundle inst0 rd=5 wr_en, inst1 rs2=5 -> only slot 0 dispatches. Repeat with inst1 rs1=6, rd=7 -> both dispatch; R gains bits 5 and 7.
- inst0 hazard-free but fu_ready0 = 0, inst1 hazard-free -> both dispatch = 0. inst0 rd=0 wr_en -> dispatches with no reservation set.
- R[9] set; same cycle wb0 rd=9 and inst0 dispatch rd=9 (WAW blocked) -> no dispatch. Then with R[9] clear, wb1 rd=9 and dispatch rd=9 in the same cycle -> R[9] = 1 afterward and o_wb_err = 1 (clear of an unreserved register).
- wb0 = wb1 = rd 4 with R[4] set -> R[4] cleared and o_wb_err = 1 until reset. Async reset mid-cycle -> o_wb_err = 0 and R = 0 immediately.
